// File: rtl/burst_read_responder.sv
// Burst-read responder: acknowledges a word request, then fetches the enclosing 4-word block
// in wrap-around order from a pipelined memory. Optional macro BURST_STATS_EN enables burst_count.
module burst_read_responder #(
    parameter int MEM_ADDR_W = 21
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  as,
    input  logic [MEM_ADDR_W:0]   address,
    output logic                  bus_ack,
    output logic [15:0]           din,
    output logic                  burstdata_valid,
    output logic                  mem_rd,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_wait,
    input  logic                  mem_rvalid,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           burst_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [MEM_ADDR_W-1:0] base_q, base_d;
    logic [2:0]            k_q, k_d;
    logic [2:0]            r_q, r_d;
    logic                  bus_ack_q, bus_ack_d;
    logic                  valid_q, valid_d;
    logic [15:0]           din_q, din_d;
    logic                  issue_accept;
    logic                  burst_done;
    logic [1:0]            word_sel;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        k_d          = k_q;
        r_d          = r_q;
        bus_ack_d    = 1'b0;
        valid_d      = mem_rvalid && (state_q != IDLE);
        din_d        = mem_rdata;
        burst_done   = 1'b0;
        mem_rd       = (state_q == ISSUE);
        word_sel     = base_q[1:0] + k_q[1:0];
        mem_addr     = mem_rd ? {base_q[MEM_ADDR_W-1:2], word_sel} : '0;
        issue_accept = mem_rd && !mem_wait;

        case (state_q)
            IDLE: begin
                if (as) begin
                    base_d    = address[MEM_ADDR_W:1];
                    k_d       = 3'd0;
                    r_d       = 3'd0;
                    bus_ack_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                if (issue_accept) begin
                    k_d = k_q + 3'd1;
                end
                if (mem_rvalid) begin
                    r_d = r_q + 3'd1;
                end
                // Returns come back in issue order, so the 4th return implies all issues are done.
                if ((r_d == 3'd4) && (k_d == 3'd4)) begin
                    state_d    = IDLE;
                    burst_done = 1'b1;
                end else if (k_d == 3'd4) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            k_q       <= 3'd0;
            r_q       <= 3'd0;
            bus_ack_q <= 1'b0;
            valid_q   <= 1'b0;
            din_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            k_q       <= k_d;
            r_q       <= r_d;
            bus_ack_q <= bus_ack_d;
            valid_q   <= valid_d;
            din_q     <= din_d;
        end
    end

    assign bus_ack         = bus_ack_q;
    assign burstdata_valid = valid_q;
    assign din             = din_q;

`ifdef BURST_STATS_EN
    logic [15:0] count_q, count_d;
    logic        unused_bits;

    always_comb begin
        count_d = count_q;
        if (burst_done) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign burst_count = count_q;
    assign unused_bits = address[0];
`else
    logic unused_bits;

    assign burst_count = 16'd0;
    assign unused_bits = address[0] ^ burst_done;
`endif

endmodule

// File: tb/tb_burst_read_responder.sv
// Randomized scoreboard bench for burst_read_responder with a pipelined memory model.
module tb_burst_read_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        as = 1'b0;
    logic [21:0] address = '0;
    logic        bus_ack;
    logic [15:0] din;
    logic        burstdata_valid;
    logic        mem_rd;
    logic [20:0] mem_addr;
    logic        mem_wait = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] burst_count;

    burst_read_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .as              (as),
        .address         (address),
        .bus_ack         (bus_ack),
        .din             (din),
        .burstdata_valid (burstdata_valid),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_wait        (mem_wait),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .burst_count     (burst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    ret_t        pipe[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          wait_pct = 0;
    int          gap_pct = 0;
    int          stall_issue = -1;
    int          stall_left = 0;
    logic [15:0] salt = '0;

    int checks = 0;
    int errors = 0;

    // Reference model of the responder, in terms of bursts rather than states
    bit          armed = 0;
    bit          busy = 0;
    bit          exp_ack = 0;
    bit          exp_bdv = 0;
    bit          rst_prev = 0;
    int          issued = 0;
    int          returns = 0;
    int          rd_cycles = 0;
    int          wait_cycles = 0;
    int          exp_count = 0;
    int          addr_q[$];
    logic [15:0] data_q[$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
    endtask

    function automatic void mem_push(input logic [15:0] data);
        int   due;
        ret_t e;
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        e.due  = due;
        e.data = data;
        pipe.push_back(e);
    endfunction

    // Memory driver: decides wait and return data shortly after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (stall_left > 0 && mem_rd === 1'b1 && issued == stall_issue) begin
            mem_wait = 1'b1;
            stall_left--;
        end else begin
            mem_wait = (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);
        end
        if (pipe.size() > 0 && pipe[0].due <= cyc &&
            !((gap_pct > 0) && (int'($urandom_range(99)) < gap_pct))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pipe[0].data;
            void'(pipe.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
    end

    // Monitor: compares this cycle's outputs, then advances the reference model
    always @(negedge clk) begin
        if (armed) begin
            if (rst_prev) begin
                check_output("reset_bus_ack", 32'(bus_ack), 32'd0);
                check_output("reset_valid", 32'(burstdata_valid), 32'd0);
                check_output("reset_din", 32'(din), 32'd0);
                check_output("reset_mem_rd", 32'(mem_rd), 32'd0);
                check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
            end
            check_output("bus_ack", 32'(bus_ack), 32'(exp_ack));
            check_output("burstdata_valid", 32'(burstdata_valid), 32'(exp_bdv));
            if (burstdata_valid === 1'b1 && data_q.size() > 0) begin
                check_output("din", 32'(din), 32'(data_q.pop_front()));
            end
            check_output("mem_rd", 32'(mem_rd), 32'(busy && issued < 4));
            check_output("burst_count", 32'(burst_count), 32'(exp_count));
            if (mem_rd === 1'b1) begin
                rd_cycles++;
                if (mem_wait) wait_cycles++;
            end
            if (mem_rd === 1'b1 && !mem_wait) begin
                if (addr_q.size() > 0) begin
                    check_output("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end
                issued++;
            end
        end

        if (mem_rd === 1'b1 && !mem_wait) mem_push(mem_addr[15:0] ^ salt);

        rst_prev = !reset_n;
        if (!reset_n) begin
            armed   = 1;
            busy    = 0;
            exp_ack = 0;
            exp_bdv = 0;
            exp_count = 0;
            issued  = 0;
            returns = 0;
            addr_q.delete();
            data_q.delete();
        end else if (!busy) begin
            exp_bdv = 0;
            exp_ack = as;
            if (as) begin
                int word;
                int a;
                busy        = 1;
                issued      = 0;
                returns     = 0;
                rd_cycles   = 0;
                wait_cycles = 0;
                word = int'(address[21:1]);
                for (int i = 0; i < 4; i++) begin
                    a = (word & ~3) | ((word + i) & 3);
                    addr_q.push_back(a);
                    data_q.push_back(16'(a) ^ salt);
                end
            end
        end else begin
            exp_ack = 0;
            exp_bdv = mem_rvalid;
            if (mem_rvalid) returns++;
            if (returns == 4) begin
                busy = 0;
                check_output("issue_cycles", 32'(rd_cycles), 32'(4 + wait_cycles));
`ifdef BURST_STATS_EN
                exp_count = (exp_count + 1) & 16'hFFFF;
`endif
            end
        end
    end

    task automatic apply_stimulus(input logic [21:0] addr, input bit hold);
        bit acked = 0;
        address = addr;
        as = 1'b1;
        for (int i = 0; i < 100 && !acked; i++) begin
            @(posedge clk);
            #2;
            acked = (bus_ack === 1'b1);
        end
        if (!acked) report_timeout("ack_wait");
        if (!hold) as = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!busy && pipe.size() == 0) done = 1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        if (!done) report_timeout("idle_wait");
    endtask

    task automatic set_memory(input int lmin, input int lmax, input int wpct, input int gpct);
        lat_min  = lmin;
        lat_max  = lmax;
        wait_pct = wpct;
        gap_pct  = gpct;
    endtask

    initial begin
        int acks;
        bit ok;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Wrap order: data equals word address, latency 3
        salt = 16'h0000;
        set_memory(3, 3, 0, 0);
        apply_stimulus(22'h000104, 0);
        wait_idle(200);

        // Aligned start, second request held high for minimum turnaround
        apply_stimulus(22'h000100, 1);
        address = 22'h00023A;
        acks = 0;
        for (int i = 0; i < 100 && acks == 0; i++) begin
            @(posedge clk);
            #2;
            if (bus_ack === 1'b1) acks = 1;
        end
        if (acks == 0) report_timeout("second_ack");
        as = 1'b0;
        wait_idle(200);

        // Stall on the second issue
        stall_issue = 1;
        stall_left  = 2;
        set_memory(2, 2, 0, 0);
        apply_stimulus(22'h0011F6, 0);
        wait_idle(200);
        check_output("stall_cycles", 32'(wait_cycles), 32'd2);
        stall_issue = -1;

        // Randomized bursts
        for (int n = 0; n < 16; n++) begin
            salt = 16'($urandom);
            set_memory(1, int'($urandom_range(6, 1)), int'($urandom_range(40)), int'($urandom_range(40)));
            apply_stimulus(22'($urandom), 0);
            wait_idle(400);
        end

        // Busy: request held from reset
        set_memory(1, 3, 20, 20);
        reset_n = 1'b0;
        as      = 1'b1;
        address = 22'h2AAAAA;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 300 && acks < 3; i++) begin
            @(posedge clk);
            #2;
            if (bus_ack === 1'b1) begin
                acks++;
                address = 22'($urandom);
            end
        end
        as = 1'b0;
        if (acks < 3) report_timeout("busy_acks");
        wait_idle(300);

        // Reset mid-burst, then stale returns must be discarded
        set_memory(5, 5, 0, 0);
        apply_stimulus(22'h000A0C, 0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (issued >= 2) ok = 1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        if (!ok) report_timeout("two_issues");
        reset_n = 1'b0;
        mem_push(16'hDEAD);
        mem_push(16'hBEEF);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        wait_idle(100);

        // Three complete bursts after the abandoned one
        for (int n = 0; n < 3; n++) begin
            set_memory(1, 4, 25, 25);
            apply_stimulus(22'($urandom), 0);
            wait_idle(400);
        end
        repeat (2) @(posedge clk);
        #2;
`ifdef BURST_STATS_EN
        check_output("burst_count_final", 32'(burst_count), 32'd3);
`else
        check_output("burst_count_final", 32'(burst_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
